// File: rtl/pattern_counter.sv
// Multi-mode pattern counter (up / down / ping-pong / optional LFSR) with a synchronised reset release.
// Optional feature: define PATTERN_COUNTER_LFSR_EN to enable the Galois LFSR in mode 3.
module pattern_counter #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             tc,
  output logic             ready
);

  typedef enum logic [1:0] {
    M_UP       = 2'd0,
    M_DOWN     = 2'd1,
    M_PINGPONG = 2'd2,
    M_LFSR     = 2'd3
  } mode_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] r_cnt;
  logic             r_dir;
  logic             r_tc;
  logic [1:0]       r_sync;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_dir_nxt;
  logic             w_tc_nxt;
  mode_t            w_mode;

  assign w_mode = mode_t'(mode);

  // Reset release: ready rises two edges after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_tc_nxt  = 1'b0;
    if (r_sync[1]) begin
      if (load) begin
        w_cnt_nxt = load_val;
        w_dir_nxt = 1'b1;
      end else if (en) begin
        case (w_mode)
          M_UP: begin
            // Above the limit the counter runs out to all-ones and wraps silently.
            if (r_cnt == limit) begin
              w_cnt_nxt = ZERO;
              w_tc_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + ONE;
            end
          end
          M_DOWN: begin
            if (r_cnt == ZERO) begin
              w_cnt_nxt = limit;
              w_tc_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - ONE;
            end
          end
          M_PINGPONG: begin
            if (r_dir) begin
              if (r_cnt >= limit) begin
                w_dir_nxt = 1'b0;
                w_tc_nxt  = 1'b1;
                w_cnt_nxt = (r_cnt == ZERO) ? ZERO : r_cnt - ONE;
              end else begin
                w_cnt_nxt = r_cnt + ONE;
              end
            end else begin
              if (r_cnt == ZERO) begin
                w_dir_nxt = 1'b1;
                w_tc_nxt  = 1'b1;
                w_cnt_nxt = (limit != ZERO) ? ONE : ZERO;
              end else begin
                w_cnt_nxt = r_cnt - ONE;
              end
            end
          end
          M_LFSR: begin
`ifdef PATTERN_COUNTER_LFSR_EN
            // Zero is the LFSR lock-up state, so kick it to 1.
            if (r_cnt == ZERO) begin
              w_cnt_nxt = ONE;
            end else begin
              w_cnt_nxt = (r_cnt >> 1) ^ (r_cnt[0] ? TAPS : ZERO);
              w_tc_nxt  = ((r_cnt >> 1) ^ (r_cnt[0] ? TAPS : ZERO)) == load_val;
            end
`else
            w_cnt_nxt = r_cnt;
`endif
          end
          default: begin
            w_cnt_nxt = r_cnt;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= ZERO;
      r_dir <= 1'b1;
      r_tc  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
      r_tc  <= w_tc_nxt;
    end
  end

  assign cnt   = r_cnt;
  assign dir   = r_dir;
  assign tc    = r_tc;
  assign ready = r_sync[1];

endmodule

// File: doc/pattern_counter.md
# pattern_counter

Parametrised multi-mode pattern counter. It generates the count values that drive the tile's output pins during bring-up and loopback tests. It extends the basic free-running 8-bit test counter with configurable width, a programmable limit, up/down/ping-pong/LFSR modes, synchronous load, a terminal-count pulse and a synchronised reset release. It sits between the pin mux and the top-level I/O wrapper; `cnt` feeds the output and bidirectional pins.

## Interface
- `WIDTH`, default 8: counter width in bits, legal range 2..16.
- `TAPS`, default `8'hB8`: Galois LFSR feedback mask, `WIDTH` bits wide; used only when `PATTERN_COUNTER_LFSR_EN` is defined.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  count enable; one step per cycle while high.
- `mode`  in  2  0=UP, 1=DOWN, 2=PINGPONG, 3=LFSR.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value written by `load`.
- `limit`  in  WIDTH  terminal value for UP, DOWN and PINGPONG.
- `cnt`  out  WIDTH  current count, registered.
- `dir`  out  1  current direction, 1=up; meaningful in PINGPONG.
- `tc`  out  1  terminal-count pulse, registered, one cycle wide.
- `ready`  out  1  high once the reset release has been synchronised.

## Operation
- Reset values: `cnt`=0, `dir`=1, `tc`=0, `ready`=0. All flops clear asynchronously on `rst`=1.
- Reset release: `rst` deassertion passes through a 2-flop synchroniser whose output is `ready`. While `ready`=0, `en` and `load` are ignored.
- Priority: `load` > `en` > hold.
  - `load`: `cnt`<=`load_val`, `dir`<=1, `tc`<=0, in every mode.
  - `en`=0 with no load: `cnt` and `dir` hold, `tc`<=0.
- UP mode:
  - `cnt`==`limit`: `cnt`<=0, `tc`<=1.
  - Otherwise: `cnt`<=`cnt`+1, modulo 2^WIDTH.
  - If `cnt`>`limit`, the counter runs to all-ones and wraps to 0 with no `tc`.
- DOWN mode:
  - `cnt`==0: `cnt`<=`limit`, `tc`<=1.
  - Otherwise: `cnt`<=`cnt`-1.
- PINGPONG mode:
  - `dir`=1 and `cnt`>=`limit`: `dir`<=0, `tc`<=1, `cnt`<=`cnt`-1 (stays 0 if `cnt`==0).
  - `dir`=1, otherwise: `cnt`<=`cnt`+1.
  - `dir`=0 and `cnt`==0: `dir`<=1, `tc`<=1, `cnt`<=1 if `limit`!=0, else stays 0.
  - `dir`=0, otherwise: `cnt`<=`cnt`-1.
  - `limit`=0 means `cnt` stays 0 and `tc`=1 on every enabled cycle.
- LFSR mode: see Configuration.
- `dir` changes only in PINGPONG and on `load`. In UP, DOWN and LFSR it holds its last value.
- A mode change takes effect on the next enabled edge and continues from the current `cnt`. No implicit reload.
- `limit` is sampled every cycle and is not latched. A change mid-count applies immediately, including the `cnt`>`limit` case above.

## Timing
- Latency: `cnt`, `dir` and `tc` update on the same rising edge that samples `en`/`load`. No combinational path from any input to any output.
- `tc` is high for exactly the cycle in which `cnt` shows the wrapped or turned value.
- After `rst` falls:
  - `ready` rises after the 2nd rising edge.
  - The first count or load takes effect on the 3rd rising edge.
- `rst` asserted mid-operation clears every output within the same cycle, with no clock edge needed.
- Throughput: one step per cycle, indefinitely.

## Configuration
- Macro `PATTERN_COUNTER_LFSR_EN`.
- Defined, LFSR mode active (`mode`=3):
  - `cnt`<=(`cnt`>>1) ^ (`cnt`[0] ? `TAPS` : 0).
  - `cnt`==0 is replaced by 1 on the next enabled edge, with no `tc`.
  - `tc`<=1 when the new value equals `load_val`.
- Not defined: `mode`=3 holds `cnt` with `tc`=0, and no LFSR logic is synthesised.

## Test plan
- Reset release, WIDTH=8, UP, `limit`=3, `en`=1: drop `rst` -> `ready`=1 after edge 2; `cnt` 0,1,2,3,0 from edge 3 on; `tc`=1 only with the second 0.
- DOWN, `limit`=5, load 2 -> `cnt` 2,1,0,5,4; `tc` high with the 5.
- PINGPONG, `limit`=3, from reset -> `cnt` 0,1,2,3,2,1,0,1; `tc` with the first 2 and the second 1; `dir` 1→0→1. With `limit`=0 -> `cnt`=0 and `tc`=1 every cycle.
- UP, `cnt`=10, `limit` changed to 4 -> `cnt` 11..255,0,1..4,0; the 255→0 wrap has `tc`=0, the 4→0 wrap has `tc`=1.
- Simultaneous `load`=1 and `en`=1 with `load_val`=0x7E -> `cnt`=0x7E, `tc`=0. Then `rst` pulsed mid-count -> `cnt`=0 and `ready`=0 immediately.
- With `PATTERN_COUNTER_LFSR_EN`, `TAPS`=0xB8, load 1, `mode`=3 -> `cnt` 0xB8, 0x5C, 0x2E, and a period of 255. Without the macro -> `cnt` holds at 1.
